// File: rtl/fifo_flex.sv
// Single-clock stream FIFO of any depth, with a first-word-fall-through or registered read port, occupancy and error flags.
// Latency: data is readable the cycle after its write (FWFT), one cycle later in registered mode. Writes are refused while full and reads while empty.
module fifo_flex #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 16,
   parameter int FWFT     = 1,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             w_valid,
   input  logic [WIDTH-1:0] data_in,
   input  logic             r_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             rd_valid,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   input  logic             flush,
   output logic             overflow,
   output logic             underflow,
   input  logic             err_clr
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_nxt;
   logic             push;
   logic             pop;

   // Full/empty are the registered pre-edge flags, so a simultaneous pop never frees room for a push.
   assign push = w_valid & ~fifo_full;
   assign pop  = r_ready & ~fifo_empty;

   // Explicit wrap so that non-power-of-2 depths never address past the last entry.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = '0;
      else if (push && !pop)
         count_nxt = count + 1'b1;
      else if (pop && !push)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         fifo_full    <= 1'b0;
         fifo_empty   <= 1'b1;
         almost_full  <= (AF_LEVEL <= 0);
         almost_empty <= (AE_LEVEL >= 0);
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         count        <= count_nxt;
         fifo_full    <= (count_nxt == CW'(DEPTH));
         fifo_empty   <= (count_nxt == '0);
         almost_full  <= (int'(count_nxt) >= AF_LEVEL);
         almost_empty <= (int'(count_nxt) <= AE_LEVEL);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
               rd_ptr <= ptr_inc(rd_ptr);
         end
         // A fresh error outranks a clear arriving in the same cycle.
         if (w_valid && fifo_full && !flush)
            overflow <= 1'b1;
         else if (err_clr)
            overflow <= 1'b0;
         if (r_ready && fifo_empty && !flush)
            underflow <= 1'b1;
         else if (err_clr)
            underflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Forced to zero while empty so the port never shows a stale or uninitialised entry.
         assign data_out = fifo_empty ? '0 : mem[rd_ptr];
         assign rd_valid = ~fifo_empty;
      end else begin : g_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_out <= '0;
               rd_valid <= 1'b0;
            end else if (flush) begin
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= pop;
               if (pop)
                  data_out <= mem[rd_ptr];
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_fifo_flex.sv
`timescale 1ns/1ps
// Scoreboard bench for fifo_flex: six instances (DEPTH 1/5/16, FWFT 1/0) share one stimulus stream, each with its own queue model.
module tb_fifo_flex;
   localparam int N = 6;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        w_valid = 1'b0;
   logic        r_ready = 1'b0;
   logic        flush   = 1'b0;
   logic        err_clr = 1'b0;
   logic [15:0] data_in = '0;

   logic [7:0]  cnt_o   [N];
   logic [15:0] dout_o  [N];
   logic        rv_o    [N];
   logic        full_o  [N];
   logic        empty_o [N];
   logic        af_o    [N];
   logic        ae_o    [N];
   logic        ovf_o   [N];
   logic        udf_o   [N];
   int          pend    [N];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   for (genvar gi = 0; gi < N; gi++) begin : g_cfg
      localparam int D  = (gi % 3 == 0) ? 1 : ((gi % 3 == 1) ? 5 : 16);
      localparam int FW = (gi < 3) ? 1 : 0;
      localparam int C  = $clog2(D + 1);

      logic [C-1:0] cnt;
      logic [15:0]  dout;
      logic         rv, ff, fe, af, ae, ov, un;
      int           mq [$];
      int           eq [$];
      bit           m_ov = 1'b0;
      bit           m_un = 1'b0;
      bit           m_rv = 1'b0;

      fifo_flex #(.WIDTH(16), .DEPTH(D), .FWFT(FW)) u_dut (
         .clk(clk), .rst(rst), .w_valid(w_valid), .data_in(data_in), .r_ready(r_ready),
         .data_out(dout), .rd_valid(rv), .fifo_full(ff), .fifo_empty(fe),
         .almost_full(af), .almost_empty(ae), .count(cnt), .flush(flush),
         .overflow(ov), .underflow(un), .err_clr(err_clr)
      );

      assign cnt_o[gi]   = 8'(cnt);
      assign dout_o[gi]  = dout;
      assign rv_o[gi]    = rv;
      assign full_o[gi]  = ff;
      assign empty_o[gi] = fe;
      assign af_o[gi]    = af;
      assign ae_o[gi]    = ae;
      assign ovf_o[gi]   = ov;
      assign udf_o[gi]   = un;

      // Reference model: checks state, then applies this cycle's inputs for the coming edge.
      always @(negedge clk) begin : model
         int sz;
         bit pshv;
         bit popv;
         if (rst) begin
            mq.delete();
            eq.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            m_rv = 1'b0;
         end
         sz = mq.size();
         chk($sformatf("count[%0d]", gi), int'(cnt), sz);
         chk($sformatf("full[%0d]", gi), int'(ff), int'(sz == D));
         chk($sformatf("empty[%0d]", gi), int'(fe), int'(sz == 0));
         chk($sformatf("almost_full[%0d]", gi), int'(af), int'(sz >= D - 1));
         chk($sformatf("almost_empty[%0d]", gi), int'(ae), int'(sz <= 1));
         chk($sformatf("overflow[%0d]", gi), int'(ov), int'(m_ov));
         chk($sformatf("underflow[%0d]", gi), int'(un), int'(m_un));
         chk($sformatf("rd_valid[%0d]", gi), int'(rv), (FW != 0) ? int'(sz != 0) : int'(m_rv));
         if (!rst) begin
            if (w_valid && sz == D && !flush) m_ov = 1'b1;
            else if (err_clr) m_ov = 1'b0;
            if (r_ready && sz == 0 && !flush) m_un = 1'b1;
            else if (err_clr) m_un = 1'b0;
            pshv = w_valid && (sz < D) && !flush;
            popv = r_ready && (sz > 0) && !flush;
            if (flush) mq.delete();
            if (popv) eq.push_back(mq.pop_front());
            if (pshv) mq.push_back(int'(data_in));
            m_rv = popv;
         end
      end

      if (FW != 0) begin : g_mon
         always begin : mon
            int v;
            @(negedge clk);
            #1;
            if (!rst && !flush && r_ready && rv) begin
               if (eq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL pop_data[%0d] actual=%0h expected=none at %0t", gi, dout, $time);
               end else begin
                  v = eq.pop_front();
                  chk($sformatf("pop_data[%0d]", gi), int'(dout), v);
               end
            end
            pend[gi] = eq.size();
         end
      end else begin : g_mon
         always begin : mon
            int v;
            @(negedge clk);
            #1;
            if (rv) begin
               if (eq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rd_data[%0d] actual=%0h expected=none at %0t", gi, dout, $time);
               end else begin
                  v = eq.pop_front();
                  chk($sformatf("rd_data[%0d]", gi), int'(dout), v);
               end
            end
            pend[gi] = eq.size();
         end
      end
   end

   task automatic cyc(input bit wv, input int d, input bit rr, input bit fl = 1'b0, input bit ec = 1'b0);
      w_valid = wv;
      data_in = 16'(d);
      r_ready = rr;
      flush   = fl;
      err_clr = ec;
      @(posedge clk);
      #1;
      w_valid = 1'b0;
      r_ready = 1'b0;
      flush   = 1'b0;
      err_clr = 1'b0;
   endtask

   // Instance 1 is DEPTH=5/FWFT=1, instance 4 is DEPTH=5/FWFT=0, instance 0 is DEPTH=1/FWFT=1.
   initial begin
      int wp;
      int rp;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", cnt_o[1], 0);
      chk("rst_empty", empty_o[1], 1);
      chk("rst_full", full_o[1], 0);
      chk("rst_ae", ae_o[1], 1);
      chk("rst_af", af_o[1], 0);
      chk("rst_af_depth1", af_o[0], 1);
      chk("rst_ovf", ovf_o[1], 0);
      chk("rst_udf", udf_o[1], 0);
      chk("rst_rv_reg", rv_o[4], 0);
      chk("rst_dout_reg", dout_o[4], 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, i, 1'b0);
         chk("fill_count", cnt_o[1], (i < 5) ? i + 1 : 5);
         chk("fill_af", af_o[1], int'(i >= 3));
         chk("fill_full", full_o[1], int'(i >= 4));
      end
      chk("fill_ovf", ovf_o[1], 1);
      for (int i = 0; i < 5; i++) begin
         chk("drain_head", dout_o[1], i);
         cyc(1'b0, 0, 1'b1);
         chk("drain_reg_data", dout_o[4], i);
         chk("drain_reg_valid", rv_o[4], 1);
      end
      chk("drain_empty", empty_o[1], 1);
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
      chk("ovf_cleared", ovf_o[1], 0);

      cyc(1'b1, 8, 1'b0);
      cyc(1'b1, 9, 1'b0);
      chk("stream_start_count", cnt_o[1], 2);
      for (int k = 0; k < 12; k++) begin
         chk("stream_head", dout_o[1], 8 + k);
         cyc(1'b1, 10 + k, 1'b1);
         chk("stream_count", cnt_o[1], 2);
      end
      for (int k = 0; k < 2; k++) begin
         chk("stream_tail", dout_o[1], 20 + k);
         cyc(1'b0, 0, 1'b1);
      end
      chk("stream_empty", empty_o[1], 1);

      cyc(1'b1, 'hA5, 1'b0);
      chk("reg_idle_valid", rv_o[4], 0);
      cyc(1'b0, 0, 1'b1);
      chk("reg_pop_valid", rv_o[4], 1);
      chk("reg_pop_data", dout_o[4], 'hA5);
      cyc(1'b0, 0, 1'b0);
      chk("reg_after_valid", rv_o[4], 0);
      chk("reg_hold_data", dout_o[4], 'hA5);

      cyc(1'b0, 0, 1'b1);
      chk("udf_set", udf_o[1], 1);
      cyc(1'b0, 0, 1'b0);
      chk("udf_sticky", udf_o[1], 1);
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
      chk("udf_clr", udf_o[1], 0);
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b1);
      chk("udf_err_beats_clr", udf_o[1], 1);
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
      chk("udf_clr2", udf_o[1], 0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 100 + i, 1'b0);
      chk("pre_flush_count", cnt_o[1], 3);
      cyc(1'b1, 77, 1'b1, 1'b1, 1'b0);
      chk("flush_count", cnt_o[1], 0);
      chk("flush_empty", empty_o[1], 1);
      chk("flush_ae", ae_o[1], 1);
      chk("flush_udf", udf_o[1], 0);
      cyc(1'b1, 'h33, 1'b0);
      chk("post_flush_count", cnt_o[1], 1);
      chk("post_flush_head", dout_o[1], 'h33);
      cyc(1'b0, 0, 1'b1);

      wp = 50;
      rp = 50;
      for (int c = 0; c < 10000; c++) begin
         if (c % 500 == 0) begin
            wp = $urandom_range(80, 20);
            rp = $urandom_range(80, 20);
         end
         rst     = ($urandom_range(999) < 3);
         w_valid = ($urandom_range(99) < wp);
         r_ready = ($urandom_range(99) < rp);
         flush   = ($urandom_range(99) < 1);
         err_clr = ($urandom_range(99) < 3);
         data_in = 16'($urandom);
         @(posedge clk);
         #1;
      end
      rst     = 1'b0;
      w_valid = 1'b0;
      r_ready = 1'b0;
      flush   = 1'b0;
      err_clr = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) chk($sformatf("undelivered[%0d]", i), pend[i], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
